tt_um_byte_port_fifo: RTL and testbench



---
 rtl/tt_um_byte_port_fifo.sv | 160 ++++++++++++++++
 tb/tb_tt_um_byte_port_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_byte_port_fifo.sv
// -----------------------------------------------------------------------------
// tt_um_byte_port_fifo
//
// Tiny Tapeout user project: a byte FIFO operated by an external tester that
// is not synchronous to clk. Control strobes and the write data byte are
// synchronised, strobes are edge-detected, and the FIFO status is published
// on uo_out one cycle after the FIFO state commits.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset; clears all state immediately
//   ena      unused (always 1 when powered)
//   ui_in    [0] wr_strobe, [1] rd_strobe, [2] drive_en, [3] err_clear,
//            [7:4] unused
//   uio_in   write data byte
//   uio_out  last popped byte
//   uio_oe   all bits = synchronised drive_en
//   uo_out   [4:0] occupancy, [5] empty, [6] full, [7] sticky error
// -----------------------------------------------------------------------------
module tt_um_byte_port_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = AW + 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
  // Events are masked until the synchroniser and the previous-value flops
  // hold only post-reset samples, so a strobe held across reset release
  // cannot look like a fresh rising edge.
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  // Synchroniser chain: {uio_in, ui_in[3:0]}
  logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
  logic [11:0] sync_out;
  logic        wr_sync, rd_sync, drv_sync, clr_sync;
  logic [7:0]  data_sync;

  logic [2:0]       prev_q, prev_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic             armed;
  logic             push_ev, pop_ev, clr_ev;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          err_q, err_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    uo_q, uo_d;

  logic empty, full, do_push, do_pop, overflow, underflow;
  logic unused_pins;

  assign unused_pins = &{1'b0, ena, ui_in[7:4]};

  always_comb begin
    sync_d[0] = {uio_in, ui_in[3:0]};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign wr_sync   = sync_out[0];
  assign rd_sync   = sync_out[1];
  assign drv_sync  = sync_out[2];
  assign clr_sync  = sync_out[3];
  assign data_sync = sync_out[11:4];

  // Edge detection
  assign prev_d  = {clr_sync, rd_sync, wr_sync};
  assign armed   = (arm_q == ARM_DONE);
  assign arm_d   = armed ? arm_q : arm_q + ARM_W'(1);
  assign push_ev = armed & wr_sync  & ~prev_q[0];
  assign pop_ev  = armed & rd_sync  & ~prev_q[1];
  assign clr_ev  = armed & clr_sync & ~prev_q[2];

  // FIFO control
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OCC_FULL);
  assign do_pop    = pop_ev & ~empty;
  // A push into a full FIFO succeeds when a pop frees the slot in the same cycle.
  assign do_push   = push_ev & (~full | do_pop);
  assign underflow = pop_ev & empty;
  assign overflow  = push_ev & full & ~do_pop;

  always_comb begin
    occ_d   = occ_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d  = rptr_q + AW'(1);
      rdata_d = mem_q[rptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    // A new fault outranks a coincident clear.
    if (overflow || underflow) begin
      err_d = 1'b1;
    end else if (clr_ev) begin
      err_d = 1'b0;
    end
    uo_d = {err_q, full, empty, 5'(occ_q)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      uo_q    <= 8'h20;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      uo_q    <= uo_d;
    end
  end

  // Storage is not reset; its contents are meaningless once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_sync;
    end
  end

  assign uio_out = rdata_q;
  assign uio_oe  = {8{drv_sync}};
  assign uo_out  = uo_q;

endmodule

// File: tb/tb_tt_um_byte_port_fifo.sv
// -----------------------------------------------------------------------------
// tb_tt_um_byte_port_fifo
//
// Bench for tt_um_byte_port_fifo. A pin-level model keeps the FIFO as a byte
// queue: a strobe counts as an event when the pins were sampled low and then
// high on consecutive post-reset edges, and that event takes effect SS edges
// after the high sample; uo_out shows the state as it stood one edge earlier.
// Directed sequences add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_tt_um_byte_port_fifo;

  localparam int DEPTH = 8;
  localparam int SS    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out, uio_oe, uo_out;

  int checks = 0;
  int errors = 0;
  logic drv = 1'b0;

  tt_um_byte_port_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       v;
    logic [3:0] ui;
    logic [7:0] d;
  } samp_t;

  samp_t      hist [0:7];
  logic [7:0] fq [$];
  logic [7:0] last_m = 8'h00;
  logic       err_m = 1'b0;
  logic [7:0] uo_exp = 8'h20;
  logic [7:0] uio_exp = 8'h00;
  logic [7:0] oe_exp = 8'h00;
  logic       m_pe, m_pp, m_ce, m_set;
  int         m_n;

  function automatic logic rise(input samp_t hi, input samp_t lo, input int b);
    return hi.v && lo.v && hi.ui[b] && !lo.ui[b];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      fq.delete();
      last_m  = 8'h00;
      err_m   = 1'b0;
      uo_exp  = 8'h20;
      uio_exp = 8'h00;
      oe_exp  = 8'h00;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{v: 1'b1, ui: ui_in[3:0], d: uio_in};
      m_n    = fq.size();
      uo_exp = {err_m, (m_n == DEPTH), (m_n == 0), 5'(m_n)};
      m_pe   = rise(hist[SS], hist[SS+1], 0);
      m_pp   = rise(hist[SS], hist[SS+1], 1);
      m_ce   = rise(hist[SS], hist[SS+1], 3);
      m_set  = 1'b0;
      if (m_pp) begin
        if (fq.size() == 0) m_set = 1'b1;
        else last_m = fq.pop_front();
      end
      if (m_pe) begin
        if (fq.size() == DEPTH) m_set = 1'b1;
        else fq.push_back(hist[SS].d);
      end
      if (m_set) err_m = 1'b1;
      else if (m_ce) err_m = 1'b0;
      uio_exp = last_m;
      oe_exp  = {8{hist[SS-1].v & hist[SS-1].ui[2]}};
    end
  end

  always @(negedge clk) begin
    chk("model uo_out", uo_out, uo_exp);
    chk("model uio_out", uio_out, uio_exp);
    chk("model uio_oe", uio_oe, oe_exp);
  end

  // ---------------- stimulus ----------------
  task automatic set_ctl(input logic [3:0] bits);
    ui_in = {4'h0, bits[3], drv, bits[1:0]};
  endtask

  // One strobe: data set a cycle ahead, strobe high two cycles, then settle.
  task automatic strobe(input logic [3:0] bits, input logic [7:0] data);
    @(negedge clk); #1 uio_in = data;
    @(negedge clk); #1 set_ctl(bits);
    @(negedge clk);
    @(negedge clk); #1 set_ctl(4'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    strobe(4'b0001, b);
  endtask

  task automatic pop_expect(input string nm, input logic [7:0] b);
    strobe(4'b0010, 8'h00);
    chk(nm, uio_out, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset uo_out", uo_out, 8'h20);
    chk("reset uio_oe", uio_oe, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Fill to full
    for (int i = 1; i <= 8; i++) push(8'(i * 17));
    chk("fill full", uo_out, 8'h48);

    // Overflow
    push(8'h99);
    chk("overflow status", uo_out, 8'hC8);

    // Drain with the bus driven
    @(negedge clk); #1 drv = 1'b1; set_ctl(4'h0);
    pop_expect("pop first", 8'h11);
    chk("drive oe", uio_oe, 8'hFF);
    chk("pop first status", uo_out, 8'h87);
    strobe(4'b1000, 8'h00);
    chk("err clear", uo_out, 8'h07);
    for (int i = 2; i <= 8; i++) pop_expect("drain", 8'(i * 17));
    chk("drained", uo_out, 8'h20);

    // Underflow with simultaneous push
    strobe(4'b0011, 8'hA5);
    chk("underflow+push status", uo_out, 8'h81);
    chk("underflow uio_out held", uio_out, 8'h88);
    pop_expect("pop after underflow", 8'hA5);
    chk("after pop status", uo_out, 8'hA0);
    strobe(4'b1000, 8'h00);
    chk("clear after underflow", uo_out, 8'h20);

    // Wrap-around with occupancy 1..3
    push(8'h00);
    push(8'h01);
    for (int i = 2; i < 20; i++) begin
      push(8'(i));
      pop_expect("wrap pop", 8'(i - 2));
    end
    pop_expect("wrap tail", 8'h12);
    pop_expect("wrap tail", 8'h13);
    chk("wrap no error", uo_out, 8'h20);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    strobe(4'b0011, 8'hEE);
    chk("full push+pop status", uo_out, 8'h48);
    chk("full push+pop data", uio_out, 8'hB0);
    for (int i = 1; i < 8; i++) pop_expect("full drain", 8'hB0 + 8'(i));
    pop_expect("full drain last", 8'hEE);
    chk("full drain status", uo_out, 8'h20);

    // Mid-operation reset with three bytes queued, strobe held across release
    push(8'h31);
    push(8'h32);
    push(8'h33);
    chk("three queued", uo_out, 8'h03);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset uo_out", uo_out, 8'h20);
    chk("midreset uio_oe", uio_oe, 8'h00);
    chk("midreset uio_out", uio_out, 8'h00);
    uio_in = 8'h77;
    set_ctl(4'b0001);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no push on release", uo_out, 8'h20);
    #1 set_ctl(4'h0);
    repeat (3) @(negedge clk);
    push(8'h5A);
    pop_expect("post reset pop", 8'h5A);

    // Latency: level held 10 cycles gives one push, visible 4 edges on
    @(negedge clk); #1 uio_in = 8'h3C;
    @(negedge clk); #1 set_ctl(4'b0001);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("latency occ", uo_out, (k < 4) ? 8'h20 : 8'h01);
    end
    repeat (6) @(negedge clk);
    chk("level one push", uo_out, 8'h01);
    #1 set_ctl(4'h0);
    repeat (3) @(negedge clk);
    pop_expect("latency pop", 8'h3C);
    chk("final status", uo_out, 8'h20);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
